// File: rtl/trng_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : trng_conditioner
// Function : Von Neumann debiaser, MSB-first word packer and show-ahead FIFO
//            with saturating drop count. Define TRNG_HEALTH_EN to build the
//            repetition-count health test on the raw stream.
// Revision : 1.0
// ============================================================================
module trng_conditioner #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 4,
  parameter int RCT_CUTOFF = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic                       raw_bit,
  input  logic                       raw_valid,
  input  logic                       rd_en,
  input  logic                       clear_fail,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       rd_valid,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic [7:0]                 drop_cnt,
  output logic                       health_fail
);

  localparam int c_lw = $clog2(DEPTH+1);
  localparam int c_pw = $clog2(DEPTH);
  localparam int c_cw = $clog2(WIDTH);
  localparam logic [c_lw-1:0]  c_depth    = c_lw'(DEPTH);
  localparam logic [c_cw-1:0]  c_last_idx = c_cw'(WIDTH-1);
  localparam logic [WIDTH-1:0] c_msb_one  = {1'b1, {(WIDTH-1){1'b0}}};

  logic             r_have_prev;
  logic             r_prev;
  logic [WIDTH-1:0] r_word;
  logic [c_cw-1:0]  r_bitcnt;

  logic             w_sample;
  logic             w_trip;
  logic             w_fail;
  logic             w_bit_ok;
  logic             w_last;
  logic             w_push;
  logic             w_pop;
  logic             w_wr;
  logic             w_full;
  logic             w_empty;
  logic [WIDTH-1:0] w_mask;
  logic [WIDTH-1:0] w_word_nx;

  assign w_sample  = enable & raw_valid & ~w_fail;
  // Second sample of a differing pair yields the second sample's value.
  assign w_bit_ok  = w_sample & r_have_prev & (r_prev != raw_bit);
  assign w_last    = (r_bitcnt == c_last_idx);
  assign w_mask    = c_msb_one >> r_bitcnt;
  assign w_word_nx = raw_bit ? (r_word | w_mask) : r_word;
  assign w_push    = w_bit_ok & w_last & ~w_trip;

`ifdef TRNG_HEALTH_EN
  localparam logic [7:0] c_cutoff = 8'(RCT_CUTOFF);

  logic [7:0] r_run_cnt;
  logic [7:0] w_run_nx;
  logic       r_last_raw;
  logic       r_health_fail;

  // A zero count means no reference sample yet, so the next one starts a run.
  assign w_run_nx = ((r_run_cnt != 8'd0) && (raw_bit == r_last_raw)) ?
                    (r_run_cnt + 8'd1) : 8'd1;
  assign w_trip   = w_sample & (w_run_nx == c_cutoff) & ~clear_fail;
  assign w_fail   = r_health_fail;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run_cnt     <= 8'd0;
      r_last_raw    <= 1'b0;
      r_health_fail <= 1'b0;
    end else if (clear_fail) begin
      r_run_cnt     <= 8'd0;
      r_health_fail <= 1'b0;
    end else begin
      if (w_sample) begin
        r_run_cnt  <= w_run_nx;
        r_last_raw <= raw_bit;
      end
      if (w_trip) r_health_fail <= 1'b1;
    end
  end
`else
  logic w_unused_ok;
  assign w_unused_ok = clear_fail | (RCT_CUTOFF < 2);
  assign w_trip      = 1'b0;
  assign w_fail      = 1'b0;
`endif

  assign health_fail = w_fail;

  // Disable or a health trip discards any half-built pair and word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_have_prev <= 1'b0;
      r_prev      <= 1'b0;
      r_word      <= '0;
      r_bitcnt    <= '0;
    end else if (!enable || w_trip) begin
      r_have_prev <= 1'b0;
      r_word      <= '0;
      r_bitcnt    <= '0;
    end else if (w_sample) begin
      if (!r_have_prev) begin
        r_have_prev <= 1'b1;
        r_prev      <= raw_bit;
      end else begin
        r_have_prev <= 1'b0;
        if (w_bit_ok) begin
          if (w_last) begin
            r_word   <= '0;
            r_bitcnt <= '0;
          end else begin
            r_word   <= w_word_nx;
            r_bitcnt <= r_bitcnt + c_cw'(1);
          end
        end
      end
    end
  end

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_pw-1:0]  r_wr_ptr;
  logic [c_pw-1:0]  r_rd_ptr;
  logic [c_lw-1:0]  r_level;
  logic [7:0]       r_drop;

  assign w_full  = (r_level == c_depth);
  assign w_empty = (r_level == '0);
  assign w_pop   = rd_en & ~w_empty;
  // A pop in the same cycle frees the slot a full FIFO needs.
  assign w_wr    = w_push & (~w_full | w_pop);

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= w_word_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_drop   <= 8'd0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + c_pw'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + c_pw'(1);
      if (w_wr && !w_pop)      r_level <= r_level + c_lw'(1);
      else if (!w_wr && w_pop) r_level <= r_level - c_lw'(1);
      if (w_push && !w_wr && (r_drop != 8'hFF)) r_drop <= r_drop + 8'd1;
    end
  end

  assign rd_data  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign rd_valid = ~w_empty;
  assign level    = r_level;
  assign drop_cnt = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_trng_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_trng_conditioner
// Function : Directed self-checking bench for trng_conditioner (8-bit, 4 deep).
// Revision : 1.0
// ============================================================================
module tb_trng_conditioner;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       raw_bit = 1'b0;
  logic       raw_valid = 1'b0;
  logic       rd_en = 1'b0;
  logic       clear_fail = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [2:0] level;
  logic [7:0] drop_cnt;
  logic       health_fail;

  int checks = 0;
  int errors = 0;

  trng_conditioner #(.WIDTH(8), .DEPTH(4), .RCT_CUTOFF(32)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .raw_bit(raw_bit),
    .raw_valid(raw_valid), .rd_en(rd_en), .clear_fail(clear_fail),
    .rd_data(rd_data), .rd_valid(rd_valid), .level(level),
    .drop_cnt(drop_cnt), .health_fail(health_fail)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic send_sample(input logic b);
    raw_bit = b; raw_valid = 1'b1;
    tick();
    raw_valid = 1'b0;
  endtask

  // Bit 1 is sent as pair (0,1), bit 0 as (1,0); optional pop on the final edge.
  task automatic send_word(input logic [7:0] w, input logic pop_last);
    for (int i = 7; i >= 0; i--) begin
      send_sample(~w[i]);
      if (i == 0) rd_en = pop_last;
      send_sample(w[i]);
    end
    rd_en = 1'b0;
  endtask

  task automatic pop;
    rd_en = 1'b1; tick(); rd_en = 1'b0;
  endtask

  task automatic test_reset;
    #3;
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", rd_valid); end
    checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL rst_data got %h exp 00", rd_data); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL rst_level got %0d exp 0", level); end
    checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL rst_drop got %0d exp 0", drop_cnt); end
    checks++; if (health_fail !== 1'b0) begin errors++; $display("FAIL rst_health got %b exp 0", health_fail); end
    tick(); rst_n = 1'b1; tick();
  endtask

  task automatic test_basic_word;
    enable = 1'b1;
    for (int i = 0; i < 7; i++) begin
      send_sample(i[0]); send_sample(~i[0]);
    end
    send_sample(1'b1);
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL aa_early got %b exp 0", rd_valid); end
    send_sample(1'b0);
    checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL aa_valid got %b exp 1", rd_valid); end
    checks++; if (rd_data !== 8'hAA) begin errors++; $display("FAIL aa_data got %h exp aa", rd_data); end
    checks++; if (level !== 3'd1) begin errors++; $display("FAIL aa_level got %0d exp 1", level); end
    pop();
    checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL aa_popdata got %h exp 00", rd_data); end
  endtask

  task automatic test_discard;
    for (int i = 0; i < 16; i++) begin
      send_sample(i[0]); send_sample(i[0]);
    end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL disc_valid got %b exp 0", rd_valid); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL disc_level got %0d exp 0", level); end
    send_word(8'hFF, 1'b0);
    checks++; if (rd_data !== 8'hFF) begin errors++; $display("FAIL ff_data got %h exp ff", rd_data); end
    pop();
  endtask

  task automatic test_overflow;
    logic [7:0] exp_w [5];
    exp_w = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    for (int i = 0; i < 5; i++) send_word(exp_w[i], 1'b0);
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL ovf_level got %0d exp 4", level); end
    checks++; if (drop_cnt !== 8'd1) begin errors++; $display("FAIL ovf_drop got %0d exp 1", drop_cnt); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (rd_data !== exp_w[i]) begin errors++; $display("FAIL ovf_read%0d got %h exp %h", i, rd_data, exp_w[i]); end
      pop();
    end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty got %b exp 0", rd_valid); end
    checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL ovf_zero got %h exp 00", rd_data); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp_w [4];
    exp_w = '{8'hA2, 8'hA3, 8'hA4, 8'hA5};
    send_word(8'hA1, 1'b0);
    for (int i = 0; i < 3; i++) send_word(exp_w[i], 1'b0);
    send_word(8'hA5, 1'b1);
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL b2b_level got %0d exp 4", level); end
    checks++; if (drop_cnt !== 8'd1) begin errors++; $display("FAIL b2b_drop got %0d exp 1", drop_cnt); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (rd_data !== exp_w[i]) begin errors++; $display("FAIL b2b_read%0d got %h exp %h", i, rd_data, exp_w[i]); end
      pop();
    end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL b2b_end got %0d exp 0", level); end
  endtask

  task automatic test_enable_and_reset;
    for (int i = 0; i < 5; i++) begin send_sample(1'b0); send_sample(1'b1); end
    enable = 1'b0; tick(); tick(); tick(); enable = 1'b1;
    send_word(8'hC3, 1'b0);
    checks++; if (level !== 3'd1) begin errors++; $display("FAIL en_level got %0d exp 1", level); end
    checks++; if (rd_data !== 8'hC3) begin errors++; $display("FAIL en_data got %h exp c3", rd_data); end
    for (int i = 0; i < 3; i++) begin send_sample(1'b1); send_sample(1'b0); end
    rst_n = 1'b0; #2;
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL ar_valid got %b exp 0", rd_valid); end
    checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL ar_data got %h exp 00", rd_data); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL ar_level got %0d exp 0", level); end
    checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL ar_drop got %0d exp 0", drop_cnt); end
    rst_n = 1'b1;
    send_word(8'h5A, 1'b0);
    checks++; if (rd_data !== 8'h5A) begin errors++; $display("FAIL ar_word got %h exp 5a", rd_data); end
    pop();
  endtask

  task automatic test_health;
    logic exp_fail;
`ifdef TRNG_HEALTH_EN
    exp_fail = 1'b1;
`else
    exp_fail = 1'b0;
`endif
    for (int i = 0; i < 31; i++) send_sample(1'b1);
    checks++; if (health_fail !== 1'b0) begin errors++; $display("FAIL rct_31 got %b exp 0", health_fail); end
    send_sample(1'b1);
    checks++; if (health_fail !== exp_fail) begin errors++; $display("FAIL rct_32 got %b exp %b", health_fail, exp_fail); end
    send_word(8'h96, 1'b0);
    checks++; if (level !== {2'b00, ~exp_fail}) begin errors++; $display("FAIL rct_block got %0d exp %0d", level, ~exp_fail); end
    if (rd_valid) pop();
    clear_fail = 1'b1; tick(); clear_fail = 1'b0;
    checks++; if (health_fail !== 1'b0) begin errors++; $display("FAIL rct_clear got %b exp 0", health_fail); end
    send_word(8'h3C, 1'b0);
    checks++; if (rd_data !== 8'h3C) begin errors++; $display("FAIL rct_resume got %h exp 3c", rd_data); end
    pop();
  endtask

  initial begin
    test_reset();
    test_basic_word();
    test_discard();
    test_overflow();
    test_back_to_back();
    test_enable_and_reset();
    test_health();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
